// File: rtl/chart_player_pkg.sv
// Shared types and limits for the chart playback sequencer.
package chart_player_pkg;

    localparam int unsigned NOTES_MAX  = 32;
    localparam int unsigned CHARTS_MAX = 16;
    localparam int unsigned IW         = $clog2(NOTES_MAX);

    typedef struct packed {
        logic [5:0] key;
        logic [7:0] duration;
    } Note;

    typedef struct packed {
        logic [7:0]                length;
        Note [NOTES_MAX-1:0]       notes;
    } Chart;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP,
        NEXT
    } ChartPlayerState;

    function automatic logic [7:0] clamp_length(input logic [7:0] len);
        return (len > 8'(NOTES_MAX)) ? 8'(NOTES_MAX) : len;
    endfunction

    // A zero duration still sounds for one unit.
    function automatic logic [7:0] eff_duration(input logic [7:0] dur);
        return (dur == 8'd0) ? 8'd1 : dur;
    endfunction

endpackage

// File: rtl/chart_player_if.sv
// Control, storage-read and note-output signals of the chart player.
interface chart_player_if;
    import chart_player_pkg::*;

    logic       start;
    logic [7:0] chart_id;
    logic       pause;
    logic       stop;
    logic [7:0] read_chart_id;
    Chart       current_chart_data;
    logic [5:0] note_key;
    logic       note_valid;
    logic [7:0] note_index;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output start, chart_id, pause, stop, current_chart_data,
        input  read_chart_id, note_key, note_valid, note_index, busy, done, error
    );

    modport slave (
        input  start, chart_id, pause, stop, current_chart_data,
        output read_chart_id, note_key, note_valid, note_index, busy, done, error
    );

endinterface

// File: rtl/chart_player_tick_timer.sv
// Duration-unit timer: counts clk cycles into ticks and completed ticks into units.
module tick_timer #(
    parameter int unsigned TICK_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       enable_i,
    output logic       tick_o,
    output logic [7:0] units_o
);

    localparam int unsigned   CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    units_q, units_d;

    // tick_o must not depend on clear_i: the caller derives clear from tick.
    assign tick_o  = enable_i && (cnt_q == LAST);
    assign units_o = units_q;

    always_comb begin
        cnt_d   = cnt_q;
        units_d = units_q;
        if (clear_i) begin
            cnt_d   = '0;
            units_d = '0;
        end else if (enable_i) begin
            if (tick_o) begin
                cnt_d   = '0;
                units_d = units_q + 8'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            units_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/chart_player.sv
// Chart playback sequencer: fetches a chart from storage and plays its notes in real time.
module chart_player
    import chart_player_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 10_000_000,
    parameter int unsigned GAP_TICKS   = 1
) (
    input  logic           clk,
    input  logic           rst,
    chart_player_if.slave  bus
);

    ChartPlayerState     state_q, state_d;
    logic [7:0]          id_q, id_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          idx_q, idx_d;
    Note [NOTES_MAX-1:0] notes_q, notes_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic       tmr_clear;
    logic       tmr_en;
    logic       tick;
    logic [7:0] units;
    Note        cur;
    logic [7:0] dur;
    logic       id_ok;

    assign cur    = notes_q[idx_q[IW-1:0]];
    assign dur    = eff_duration(cur.duration);
    assign id_ok  = (bus.chart_id != 8'd0) && (bus.chart_id <= 8'(CHARTS_MAX));
    assign tmr_en = ((state_q == PLAY) || (state_q == GAP)) && !bus.pause;

    tick_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmr_clear),
        .enable_i (tmr_en),
        .tick_o   (tick),
        .units_o  (units)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        idx_d     = idx_q;
        notes_d   = notes_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        tmr_clear = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (id_ok) begin
                        id_d    = bus.chart_id;
                        state_d = FETCH;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                notes_d = bus.current_chart_data.notes;
                len_d   = clamp_length(bus.current_chart_data.length);
                idx_d   = '0;
                if (bus.current_chart_data.length == 8'd0) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                tmr_clear = 1'b0;
                if (tick && (units == dur - 8'd1)) begin
                    tmr_clear = 1'b1;
                    state_d   = (GAP_TICKS != 0) ? GAP : NEXT;
                end
            end
            GAP: begin
                tmr_clear = 1'b0;
                if (tick && (units == 8'(GAP_TICKS - 1))) begin
                    tmr_clear = 1'b1;
                    state_d   = NEXT;
                end
            end
            NEXT: begin
                if (idx_q + 8'd1 == len_q) begin
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides pause and the completion pulse.
        if (bus.stop && (state_q != IDLE)) begin
            state_d   = IDLE;
            idx_d     = '0;
            done_d    = 1'b0;
            error_d   = 1'b0;
            tmr_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            notes_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            notes_q <= notes_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign bus.read_chart_id = (state_q == FETCH) ? id_q : '0;
    assign bus.note_key      = ((state_q == PLAY) || (state_q == GAP) || (state_q == NEXT))
                               ? cur.key : '0;
    assign bus.note_valid    = (state_q == PLAY) && (cur.key != 6'd0) && !bus.pause;
    assign bus.note_index    = idx_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.error         = error_q;

endmodule

// File: tb/tb_chart_player.sv
// Directed bench for chart_player with a per-cycle expected-timeline model.
module tb_chart_player;
    import chart_player_pkg::*;

    localparam int TC = 4;
    localparam int GT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chart_player_if bus();

    chart_player #(
        .TICK_CYCLES(TC),
        .GAP_TICKS  (GT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    Chart charts [256];

    // Storage with one-cycle read latency.
    always @(posedge clk)
        bus.current_chart_data <= (bus.read_chart_id != 8'd0) ? charts[bus.read_chart_id] : '0;

    typedef struct packed {
        logic       busy;
        logic [7:0] rid;
        logic [5:0] key;
        logic       valid;
        logic [7:0] idx;
        logic       done;
        logic       err;
        logic       timed;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc = 0, done_cyc = 0;
    int   valid_cnt = 0, read_cnt = 0, last_read = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;

    function automatic exp_t mk(logic b, logic [7:0] r, logic [5:0] k, logic v,
                                logic [7:0] i, logic d, logic e, logic t);
        exp_t x;
        x.busy = b; x.rid = r; x.key = k; x.valid = v;
        x.idx = i; x.done = d; x.err = e; x.timed = t;
        return x;
    endfunction

    // Expected per-cycle timeline of one request, beginning the cycle after start.
    task automatic build(input int id);
        Chart c;
        int n, d, k;
        if (id < 1 || id > int'(CHARTS_MAX)) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
            return;
        end
        c = charts[id];
        exp_q.push_back(mk(1, 8'(id), 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        n = (int'(c.length) > int'(NOTES_MAX)) ? int'(NOTES_MAX) : int'(c.length);
        if (n == 0) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
            return;
        end
        for (int i = 0; i < n; i++) begin
            k = int'(c.notes[i].key);
            d = (c.notes[i].duration == 8'd0) ? 1 : int'(c.notes[i].duration);
            for (int j = 0; j < d * TC; j++)  exp_q.push_back(mk(1, 0, 6'(k), k != 0, 8'(i), 0, 0, 1));
            for (int j = 0; j < GT * TC; j++) exp_q.push_back(mk(1, 0, 6'(k), 0, 8'(i), 0, 0, 1));
            exp_q.push_back(mk(1, 0, 6'(k), 0, 8'(i), 0, 0, 0));
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    endtask

    function automatic void chk(string name, int act, int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endfunction

    exp_t       e;
    logic [25:0] act_v, want_v;

    always @(negedge clk) begin
        cyc++;
        if (bus.note_valid)            valid_cnt++;
        if (bus.read_chart_id != 8'd0) begin read_cnt++; last_read = int'(bus.read_chart_id); end
        if (bus.done)                  begin done_cnt++; done_cyc = cyc; end
        if (bus.error)                 err_cnt++;
        if (bus.busy)                  busy_cnt++;

        e = (exp_q.size() > 0) ? exp_q[0] : mk(0, 0, 0, 0, 0, 0, 0, 0);
        want_v = {e.busy, e.rid, e.key, e.valid && !bus.pause, e.idx, e.done, e.err};
        act_v  = {bus.busy, bus.read_chart_id, bus.note_key, bus.note_valid,
                  bus.note_index, bus.done, bus.error};
        checks++;
        if (act_v !== want_v) begin
            errors++;
            $display("FAIL cycle %0d outputs {busy,rid,key,valid,idx,done,err}: got %h expected %h",
                     cyc, act_v, want_v);
        end

        // Paused PLAY/GAP cycles do not consume time.
        if (exp_q.size() > 0 && !(e.timed && bus.pause)) void'(exp_q.pop_front());
        if (rst || bus.stop) begin
            exp_q.delete();
        end else if (bus.start && exp_q.size() == 0) begin
            start_cyc = cyc;
            build(int'(bus.chart_id));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int id);
        bus.chart_id = 8'(id);
        bus.start    = 1'b1;
        tick(1);
        bus.start    = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (exp_q.size() == 0) return;
            tick(1);
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: expected timeline still pending after %0d cycles, required empty", lim);
        exp_q.delete();
    endtask

    task automatic clr_mon();
        valid_cnt = 0; read_cnt = 0; last_read = 0; done_cnt = 0;
        err_cnt = 0; busy_cnt = 0; done_cyc = 0; start_cyc = 0;
    endtask

    initial begin
        bus.start = 1'b0; bus.chart_id = '0; bus.pause = 1'b0; bus.stop = 1'b0;
        for (int i = 0; i < 256; i++) charts[i] = '0;
        charts[2].length = 8'd2;
        charts[2].notes[0].key = 6'd5; charts[2].notes[0].duration = 8'd2;
        charts[2].notes[1].key = 6'd9; charts[2].notes[1].duration = 8'd1;
        charts[3].length = 8'd0;
        charts[4].length = 8'd2;
        charts[4].notes[0].key = 6'd0; charts[4].notes[0].duration = 8'd1;
        charts[4].notes[1].key = 6'd7; charts[4].notes[1].duration = 8'd0;
        charts[5].length = 8'd40;
        for (int i = 0; i < 32; i++) begin
            charts[5].notes[i].key      = 6'(i + 1);
            charts[5].notes[i].duration = 8'd1;
        end

        tick(3);
        rst = 1'b0;
        tick(2);

        // Basic playback of chart 2
        clr_mon(); pulse_start(2); wait_idle(100); tick(2);
        chk("play_latency", done_cyc - start_cyc, 25);
        chk("play_valid_cycles", valid_cnt, 12);
        chk("play_reads", read_cnt, 1);
        chk("play_read_id", last_read, 2);
        chk("play_done_pulses", done_cnt, 1);

        // Invalid ids
        clr_mon(); pulse_start(0); tick(3);
        pulse_start(int'(CHARTS_MAX) + 1); wait_idle(10); tick(2);
        chk("badid_errors", err_cnt, 2);
        chk("badid_reads", read_cnt, 0);
        chk("badid_busy", busy_cnt, 0);

        // Empty chart
        clr_mon(); pulse_start(3); wait_idle(20); tick(2);
        chk("empty_reads", read_cnt, 1);
        chk("empty_errors", err_cnt, 1);
        chk("empty_valid", valid_cnt, 0);

        // Pause for 6 cycles starting in the 3rd sounding cycle of the first note
        clr_mon(); pulse_start(2); tick(4);
        bus.pause = 1'b1; tick(6); bus.pause = 1'b0;
        wait_idle(100); tick(2);
        chk("pause_latency", done_cyc - start_cyc, 31);
        chk("pause_valid_cycles", valid_cnt, 12);

        // Stop during the first gap, then replay from note 0
        clr_mon(); pulse_start(2); tick(11);
        bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
        wait_idle(10); tick(3);
        chk("stop_done_pulses", done_cnt, 0);
        chk("stop_valid_cycles", valid_cnt, 8);
        clr_mon(); pulse_start(2); wait_idle(100); tick(2);
        chk("replay_latency", done_cyc - start_cyc, 25);

        // Start and stop together in IDLE
        clr_mon();
        bus.stop = 1'b1; pulse_start(2); bus.stop = 1'b0;
        tick(4);
        chk("startstop_reads", read_cnt, 0);

        // Rest note, zero duration, start while busy
        clr_mon(); pulse_start(4); tick(4); pulse_start(2);
        wait_idle(100); tick(2);
        chk("rest_latency", done_cyc - start_cyc, 21);
        chk("rest_valid_cycles", valid_cnt, 4);
        chk("busy_start_reads", read_cnt, 1);

        // Length clamped to NOTES_MAX
        clr_mon(); pulse_start(5); wait_idle(400); tick(2);
        chk("clamp_latency", done_cyc - start_cyc, 291);
        chk("clamp_valid_cycles", valid_cnt, 128);

        // Reset in the middle of PLAY
        clr_mon(); pulse_start(2); tick(5);
        rst = 1'b1; tick(1); rst = 1'b0;
        wait_idle(10); tick(3);
        chk("rst_done_pulses", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
